fix_lut_accum: RTL and testbench

FIX_LUT_ACCUM -- requirements
Module: fix_lut_accum

---
 rtl/fix_lut_accum.sv | 184 ++++++++++++++++++
 tb/tb_fix_lut_accum.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_lut_accum.sv
// rtl/fix_lut_accum.sv - sign-selected coefficient sum built from elaboration-time LUTs
// Each accepted sel vector is summed luts_per_step LUT lookups per cycle, then narrowed to the output word.
module fix_lut_accum #(
  parameter int size          = 24,
  parameter int lut_size      = 6,
  parameter int luts_per_step = 2,
  parameter int n_int         = 8,
  parameter int n_mant        = 23,
  parameter int saturate      = 1,
  parameter logic [size-1:0][n_int+n_mant:0] fact = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [size-1:0]       sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [n_int+n_mant:0] result,
  output logic                  ovf,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int N_TOT     = n_int + n_mant;
  localparam int W         = N_TOT + 1;
  localparam int ACC_W     = W + $clog2(size + 1);
  localparam int LUTS_NUM  = (size + lut_size - 1) / lut_size;
  localparam int STEPS_NUM = (LUTS_NUM + luts_per_step - 1) / luts_per_step;
  localparam int SLOTS     = STEPS_NUM * luts_per_step;
  localparam int SLOT_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int STEP_W    = (STEPS_NUM > 1) ? $clog2(STEPS_NUM) : 1;
  localparam int IDX_W     = (size > 1) ? $clog2(size) : 1;
  localparam int DEPTH     = 1 << lut_size;
  localparam int PAD_W     = SLOTS * lut_size;

  typedef logic [SLOTS-1:0][DEPTH-1:0][ACC_W-1:0] rom_t;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // Slots past LUTsNum stay all-zero, so the trailing step needs no range guard.
  function automatic rom_t build_rom();
    rom_t            rom;
    logic [ACC_W-1:0] coef;
    logic [ACC_W-1:0] acc;
    int              idx;
    rom = '0;
    for (int l = 0; l < LUTS_NUM; l++) begin
      for (int a = 0; a < DEPTH; a++) begin
        acc = '0;
        for (int b = 0; b < lut_size; b++) begin
          idx = l * lut_size + b;
          if (idx < size) begin
            coef = {{(ACC_W-W){fact[IDX_W'(idx)][N_TOT]}}, fact[IDX_W'(idx)]};
            if (((a >> b) & 1) != 0) acc = acc + coef;
            else                     acc = acc - coef;
          end
        end
        rom[SLOT_W'(l)][lut_size'(a)] = acc;
      end
    end
    return rom;
  endfunction

  localparam rom_t ROM = build_rom();

  state_t              state_q, state_d;
  logic [size-1:0]     sel_q, sel_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [W-1:0]        result_q, result_d;
  logic                ovf_q, ovf_d;
  logic                out_valid_q, out_valid_d;

  logic                         accept;
  logic                         last_step;
  logic [SLOTS-1:0][lut_size-1:0] addr;
  logic [SLOT_W-1:0]            slot;
  logic [ACC_W-1:0]             step_sum;
  logic [ACC_W-1:0]             acc_sum;
  logic [ACC_W-W:0]             acc_top;
  logic                         fits;
  logic [W-1:0]                 narrowed;

  assign accept    = in_valid && in_ready;
  assign last_step = (step_q == STEP_W'(STEPS_NUM - 1));
  assign addr      = PAD_W'(sel_q);

  always_comb begin
    step_sum = '0;
    slot     = '0;
    for (int k = 0; k < luts_per_step; k++) begin
      slot     = SLOT_W'(int'(step_q) * luts_per_step + k);
      step_sum = step_sum + ROM[slot][addr[slot]];
    end
  end

  // In range exactly when every bit from the output sign bit upward agrees.
  assign acc_sum = acc_q + step_sum;
  assign acc_top = acc_sum[ACC_W-1:N_TOT];
  assign fits    = (&acc_top) || !(|acc_top);

  always_comb begin
    narrowed = acc_sum[W-1:0];
    if (!fits && (saturate != 0)) begin
      narrowed = acc_sum[ACC_W-1] ? {1'b1, {N_TOT{1'b0}}} : {1'b0, {N_TOT{1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = ACCUM;
        ACCUM:   if (last_step) state_d = DONE;
        DONE:    if (out_ready) state_d = in_valid ? ACCUM : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  end

  always_comb begin
    sel_d       = sel_q;
    step_d      = step_q;
    acc_d       = acc_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      step_d      = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      sel_d       = sel;
      step_d      = '0;
      acc_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else if (state_q == ACCUM) begin
      acc_d  = acc_sum;
      step_d = step_q + STEP_W'(1);
      if (last_step) begin
        step_d      = '0;
        result_d    = narrowed;
        ovf_d       = !fits;
        out_valid_d = 1'b1;
      end
    end else if ((state_q == DONE) && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_q       <= '0;
      step_q      <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fix_lut_accum.sv
// tb/tb_fix_lut_accum.sv - five configurations driven in lockstep, checked against an arithmetic model
module tb_fix_lut_accum;

  function automatic logic [23:0][31:0] gen_fact(input logic [31:0] seed, input int shift);
    logic [23:0][31:0] r;
    logic [31:0]       x;
    x = seed;
    for (int j = 0; j < 24; j++) begin
      x    = x * 32'd1664525 + 32'd1013904223;
      r[j] = 32'($signed(x) >>> shift);
    end
    return r;
  endfunction

  localparam logic [3:0][7:0]   FACT_A   = {8'd16, 8'd8, 8'd4, 8'd2};
  localparam logic [3:0][7:0]   FACT_B   = {4{8'd100}};
  localparam logic [23:0][31:0] FACT_D   = gen_fact(32'h1234_5678, 4);
  localparam logic [23:0][31:0] FACT_E24 = gen_fact(32'h9e37_79b9, 0);
  localparam logic [19:0][31:0] FACT_E   = FACT_E24[19:0];

  localparam int SZ  [5] = '{4, 4, 4, 24, 20};
  localparam int WD  [5] = '{8, 8, 8, 32, 32};
  localparam int SAT [5] = '{1, 1, 0, 1, 0};
  localparam int LAT [5] = '{2, 2, 2, 4, 4};

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [23:0] sel = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;

  logic        rdy_a, rdy_b, rdy_c, rdy_d, rdy_e;
  logic [7:0]  res_a, res_b, res_c;
  logic [31:0] res_d, res_e;
  logic        ovf_a, ovf_b, ovf_c, ovf_d, ovf_e;
  logic        ov_a, ov_b, ov_c, ov_d, ov_e;

  always #5 clk = ~clk;

  fix_lut_accum #(.size(4), .lut_size(2), .luts_per_step(1), .n_int(3), .n_mant(4),
                  .saturate(1), .fact(FACT_A)) u_a (
    .clk(clk), .rstn(rstn), .sel(sel[3:0]), .in_valid(in_valid), .in_ready(rdy_a),
    .flush(flush), .result(res_a), .ovf(ovf_a), .out_valid(ov_a), .out_ready(out_ready));
  fix_lut_accum #(.size(4), .lut_size(2), .luts_per_step(1), .n_int(3), .n_mant(4),
                  .saturate(1), .fact(FACT_B)) u_b (
    .clk(clk), .rstn(rstn), .sel(sel[3:0]), .in_valid(in_valid), .in_ready(rdy_b),
    .flush(flush), .result(res_b), .ovf(ovf_b), .out_valid(ov_b), .out_ready(out_ready));
  fix_lut_accum #(.size(4), .lut_size(2), .luts_per_step(1), .n_int(3), .n_mant(4),
                  .saturate(0), .fact(FACT_B)) u_c (
    .clk(clk), .rstn(rstn), .sel(sel[3:0]), .in_valid(in_valid), .in_ready(rdy_c),
    .flush(flush), .result(res_c), .ovf(ovf_c), .out_valid(ov_c), .out_ready(out_ready));
  fix_lut_accum #(.size(24), .lut_size(6), .luts_per_step(1), .n_int(8), .n_mant(23),
                  .saturate(1), .fact(FACT_D)) u_d (
    .clk(clk), .rstn(rstn), .sel(sel), .in_valid(in_valid), .in_ready(rdy_d),
    .flush(flush), .result(res_d), .ovf(ovf_d), .out_valid(ov_d), .out_ready(out_ready));
  fix_lut_accum #(.size(20), .lut_size(3), .luts_per_step(2), .n_int(8), .n_mant(23),
                  .saturate(0), .fact(FACT_E)) u_e (
    .clk(clk), .rstn(rstn), .sel(sel[19:0]), .in_valid(in_valid), .in_ready(rdy_e),
    .flush(flush), .result(res_e), .ovf(ovf_e), .out_valid(ov_e), .out_ready(out_ready));

  longint cur_res [5];
  logic   cur_ovf [5];
  logic   cur_ov  [5];
  logic   cur_rdy [5];
  assign cur_res[0] = longint'($signed(res_a));
  assign cur_res[1] = longint'($signed(res_b));
  assign cur_res[2] = longint'($signed(res_c));
  assign cur_res[3] = longint'($signed(res_d));
  assign cur_res[4] = longint'($signed(res_e));
  assign cur_ovf[0] = ovf_a; assign cur_ovf[1] = ovf_b; assign cur_ovf[2] = ovf_c;
  assign cur_ovf[3] = ovf_d; assign cur_ovf[4] = ovf_e;
  assign cur_ov[0]  = ov_a;  assign cur_ov[1]  = ov_b;  assign cur_ov[2]  = ov_c;
  assign cur_ov[3]  = ov_d;  assign cur_ov[4]  = ov_e;
  assign cur_rdy[0] = rdy_a; assign cur_rdy[1] = rdy_b; assign cur_rdy[2] = rdy_c;
  assign cur_rdy[3] = rdy_d; assign cur_rdy[4] = rdy_e;

  logic [23:0][31:0] fm [5];
  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    logic [3:0] s;
    longint     ra, rb, rc;
    bit         oa, ob, oc;
  } vec_t;
  vec_t tab [6];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Plain signed sum of +/- coefficients, then range check against the output word.
  function automatic void model(input int i, input logic [23:0] s, output longint r, output bit o);
    longint sum, v, m, hi, lo;
    sum = 0;
    for (int j = 0; j < SZ[i]; j++) begin
      v = longint'($signed(fm[i][j]));
      sum += s[j] ? v : -v;
    end
    m  = longint'(1) <<< WD[i];
    hi = m / 2 - 1;
    lo = -(m / 2);
    o  = (sum > hi) || (sum < lo);
    if (!o)          r = sum;
    else if (SAT[i] != 0) r = (sum > hi) ? hi : lo;
    else begin
      r = sum & (m - 1);
      if (r > hi) r -= m;
    end
  endfunction

  task automatic start(input logic [23:0] s);
    sel = s; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) chk($sformatf("in_ready_pre_accept u%0d", i), cur_rdy[i], 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    sel = 24'($urandom);
  endtask

  task automatic collect(input longint er [5], input bit eo [5], input bit hold);
    int     lat [5];
    longint r   [5];
    bit     o   [5];
    out_ready = !hold;
    for (int i = 0; i < 5; i++) begin lat[i] = -1; r[i] = 0; o[i] = 0; end
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) @(negedge clk);
      for (int i = 0; i < 5; i++)
        if (lat[i] < 0 && cur_ov[i]) begin lat[i] = c; r[i] = cur_res[i]; o[i] = cur_ovf[i]; end
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("latency u%0d", i), lat[i], LAT[i]);
      chk($sformatf("result u%0d", i), r[i], er[i]);
      chk($sformatf("ovf u%0d", i), o[i], eo[i]);
    end
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          chk($sformatf("hold result u%0d", i), cur_res[i], er[i]);
          chk($sformatf("hold out_valid u%0d", i), cur_ov[i], 1);
          chk($sformatf("hold in_ready u%0d", i), cur_rdy[i], 0);
        end
      end
    end
  endtask

  task automatic txn(input logic [23:0] s, input bit hold);
    longint er [5];
    bit     eo [5];
    for (int i = 0; i < 5; i++) model(i, s, er[i], eo[i]);
    start(s);
    collect(er, eo, hold);
  endtask

  task automatic expect_silent(input string nm, input int cycles);
    bit seen [5];
    for (int i = 0; i < 5; i++) seen[i] = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) if (cur_ov[i]) seen[i] = 1;
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s no out_valid u%0d", nm, i), seen[i], 0);
      chk($sformatf("%s in_ready u%0d", nm, i), cur_rdy[i], 1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    longint    er [5];
    bit        eo [5];
    longint    prev [5];
    logic [23:0] s;

    for (int i = 0; i < 5; i++) fm[i] = '0;
    for (int j = 0; j < 4; j++) begin
      fm[0][j] = 32'($signed(FACT_A[j]));
      fm[1][j] = 32'($signed(FACT_B[j]));
    end
    fm[2] = fm[1];
    fm[3] = FACT_D;
    fm[4] = FACT_E24;

    tab[0] = '{4'b1111,  30,  127, -112, 0, 1, 1};
    tab[1] = '{4'b0101, -10,    0,    0, 0, 0, 0};
    tab[2] = '{4'b0000, -30, -128,  112, 0, 1, 1};
    tab[3] = '{4'b1110,  26,  127,  -56, 0, 1, 1};
    tab[4] = '{4'b1000,   2, -128,   56, 0, 1, 1};
    tab[5] = '{4'b1100,  18,    0,    0, 0, 0, 0};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("reset result u%0d", i), cur_res[i], 0);
      chk($sformatf("reset ovf u%0d", i), cur_ovf[i], 0);
      chk($sformatf("reset out_valid u%0d", i), cur_ov[i], 0);
    end
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) chk($sformatf("post-reset in_ready u%0d", i), cur_rdy[i], 1);

    for (int k = 0; k < 6; k++) begin
      s = 24'($urandom);
      s[3:0] = tab[k].s;
      for (int i = 0; i < 5; i++) model(i, s, er[i], eo[i]);
      er[0] = tab[k].ra; er[1] = tab[k].rb; er[2] = tab[k].rc;
      eo[0] = tab[k].oa; eo[1] = tab[k].ob; eo[2] = tab[k].oc;
      start(s);
      collect(er, eo, 1'b0);
    end

    // Backpressure, then handoff with a new accept on the releasing edge.
    txn(24'($urandom), 1'b1);
    txn(24'($urandom), 1'b0);

    // Flush during step 0, then flush colliding with an accept.
    for (int i = 0; i < 5; i++) prev[i] = cur_res[i];
    start(24'hFFFFFF);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("flush out_valid u%0d", i), cur_ov[i], 0);
      chk($sformatf("flush ovf u%0d", i), cur_ovf[i], 0);
      chk($sformatf("flush retains result u%0d", i), cur_res[i], prev[i]);
    end
    expect_silent("flush", 6);
    sel = 24'($urandom); in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    expect_silent("flush+accept", 6);
    txn(24'($urandom), 1'b0);

    // Asynchronous reset between edges while accumulating.
    start(24'($urandom));
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("async reset result u%0d", i), cur_res[i], 0);
      chk($sformatf("async reset out_valid u%0d", i), cur_ov[i], 0);
      chk($sformatf("async reset ovf u%0d", i), cur_ovf[i], 0);
    end
    @(negedge clk);
    rstn = 1'b1;
    expect_silent("after reset", 6);
    txn(24'($urandom), 1'b0);

    for (int k = 0; k < 40; k++) begin
      s = (k % 8 == 0) ? 24'hFFFFFF : 24'($urandom);
      txn(s, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
